// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute/writeback stage.
// Flag vectors are ordered {N,V,Z,C}, which matches the FLAG_* bit indices.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int WB_RD_W = 3;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef logic [3:0] flags_t;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_LO = 3'd3,
        COND_HS = 3'd4,
        COND_MI = 3'd5,
        COND_LT = 3'd6,
        COND_GE = 3'd7
    } cond_e;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [WB_RD_W-1:0] rd;
        logic               we;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/alu_wb_stage_skid_buf2.sv
// Generic 2-entry valid/ready FIFO. Every output comes straight from a flop.
// in_ready is a flop as well, so out_ready has no combinational path to in_ready.
module skid_buf2 #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   r_count;
    logic [1:0]   w_count_nxt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         w_push;
    logic         w_pop;

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, occupancy and handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
            // A simultaneous push and pop can only happen at count 1.
            if (w_pop) begin
                if (w_push) begin
                    r_head <= in_data;
                end else if (r_count == 2'd2) begin
                    r_head <= r_tail;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= in_data;
                end else begin
                    r_tail <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: queues ALU results toward the register file,
// maintains the {N,V,Z,C} flag register, and evaluates the branch condition.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int N    = DATA_W,
    parameter int RD_W = WB_RD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_result,
    input  logic            in_c,
    input  logic            in_z,
    input  logic            in_v,
    input  logic            in_n,
    input  logic [3:0]      in_flag_we,
    input  logic            in_chain,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic [3:0]      flags_q,
    input  logic [2:0]      cond_sel,
    output logic            cond_true
);

    localparam int W = N + RD_W + 1;

    logic         w_in_ready;
    logic         w_accept;
    logic [W-1:0] w_in_data;
    logic [W-1:0] w_out_data;
    flags_t       r_flags;
    flags_t       w_flags_new;

    assign w_in_data = {in_result, in_rd, in_we};
    assign w_accept  = in_valid & w_in_ready;
    assign in_ready  = w_in_ready;
    assign flags_q   = r_flags;
    assign {out_result, out_rd, out_we} = w_out_data;

    skid_buf2 #(.W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    // Candidate flag values; Z stays sticky across the bytes of a chained op
    always_comb begin
        w_flags_new         = 4'b0000;
        w_flags_new[FLAG_C] = in_c;
        w_flags_new[FLAG_V] = in_v;
        w_flags_new[FLAG_N] = in_n;
        if (in_chain) begin
            w_flags_new[FLAG_Z] = in_z & r_flags[FLAG_Z];
        end else begin
            w_flags_new[FLAG_Z] = in_z;
        end
    end

    // Architectural flags, written per bit under the mask on accept only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_accept) begin
            r_flags <= (r_flags & ~in_flag_we) | (w_flags_new & in_flag_we);
        end
    end

    // Branch condition from the current flags
    always_comb begin
        cond_true = 1'b1;
        case (cond_e'(cond_sel))
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = r_flags[FLAG_Z];
            COND_NE: cond_true = ~r_flags[FLAG_Z];
            COND_LO: cond_true = r_flags[FLAG_C];
            COND_HS: cond_true = ~r_flags[FLAG_C];
            COND_MI: cond_true = r_flags[FLAG_N];
            COND_LT: cond_true = r_flags[FLAG_N] ^ r_flags[FLAG_V];
            COND_GE: cond_true = ~(r_flags[FLAG_N] ^ r_flags[FLAG_V]);
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed vector table, hand sequences
// for backpressure and mid-operation reset, then randomized traffic vs a queue model.
module tb_alu_wb_stage;

    localparam int N    = 8;
    localparam int RD_W = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_result;
    logic            in_c, in_z, in_v, in_n;
    logic [3:0]      in_flag_we;
    logic            in_chain;
    logic [RD_W-1:0] in_rd;
    logic            in_we;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_we;
    logic [3:0]      flags_q;
    logic [2:0]      cond_sel;
    logic            cond_true;

    always #5 clk = ~clk;

    alu_wb_stage #(.N(N), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_c(in_c), .in_z(in_z), .in_v(in_v), .in_n(in_n),
        .in_flag_we(in_flag_we), .in_chain(in_chain), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .flags_q(flags_q),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    typedef struct {
        logic [N-1:0]    res;
        logic [RD_W-1:0] rd;
        logic            we;
    } ent_t;

    typedef struct {
        logic [N-1:0]    res;
        logic            c, z, v, n;
        logic [3:0]      mask;
        logic            chain;
        logic [RD_W-1:0] rd;
        logic            we;
        logic [2:0]      sel;
        logic [3:0]      ef;
        logic            ec;
    } vec_t;

    ent_t       mq[$];
    bit         m_ready = 1'b0;
    logic [3:0] m_flags = 4'b0000;
    int         n_pass  = 0;
    int         n_total = 0;
    vec_t       vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit ref_cond(input logic [3:0] f, input logic [2:0] s);
        bit n, v, z, c;
        {n, v, z, c} = f;
        case (s)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return c;
            3'd4: return !c;
            3'd5: return n;
            3'd6: return n ^ v;
            default: return !(n ^ v);
        endcase
    endfunction

    task automatic set_op(input logic v, input logic [N-1:0] r, input logic c, input logic z,
                          input logic ov, input logic ng, input logic [3:0] m, input logic ch,
                          input logic [RD_W-1:0] rd, input logic we);
        in_valid = v; in_result = r; in_c = c; in_z = z; in_v = ov; in_n = ng;
        in_flag_we = m; in_chain = ch; in_rd = rd; in_we = we;
    endtask

    // One clock: advance the reference model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit         acc, pop;
        ent_t       e;
        logic [3:0] src;
        acc = in_valid && m_ready;
        pop = (mq.size() != 0) && out_ready;
        src = {in_n, in_v, in_z, in_c};
        if (in_chain) src[1] = in_z && m_flags[1];
        e.res = in_result; e.rd = in_rd; e.we = in_we;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_flags = 4'b0000;
            m_ready = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                for (int i = 0; i < 4; i++) if (in_flag_we[i]) m_flags[i] = src[i];
            end
            m_ready = (mq.size() != 2);
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
        chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
        chk("cond_true", {31'd0, cond_true}, {31'd0, ref_cond(m_flags, cond_sel)});
        if (mq.size() != 0) begin
            chk("out_result", {24'd0, out_result}, {24'd0, mq[0].res});
            chk("out_rd", {29'd0, out_rd}, {29'd0, mq[0].rd});
            chk("out_we", {31'd0, out_we}, {31'd0, mq[0].we});
        end
    endtask

    initial begin
        vt[0]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd3, 1'b1, 3'd1, 4'b0010, 1'b1};
        vt[1]  = '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 3'd1, 1'b1, 3'd6, 4'b0100, 1'b1};
        vt[2]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 3'd2, 1'b1, 3'd3, 4'b1001, 1'b1};
        vt[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd4, 1'b1, 3'd1, 4'b0010, 1'b1};
        vt[4]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd4, 1'b1, 3'd1, 4'b0000, 1'b0};
        vt[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd5, 1'b1, 3'd1, 4'b0010, 1'b1};
        vt[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd5, 1'b1, 3'd1, 4'b0010, 1'b1};
        vt[7]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd6, 1'b0, 3'd1, 4'b0000, 1'b0};
        vt[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd6, 1'b1, 3'd2, 4'b0000, 1'b1};
        vt[9]  = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd7, 1'b1, 3'd5, 4'b0001, 1'b0};
        vt[10] = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 3'd0, 1'b1, 3'd4, 4'b1011, 1'b0};
        vt[11] = '{8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 3'd1, 1'b0, 3'd7, 4'b1111, 1'b1};

        // Reset held with in_valid asserted
        rst_n = 1'b0; out_ready = 1'b1; cond_sel = 3'd0;
        set_op(1'b1, 8'hAB, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_out_result", {24'd0, out_result}, 32'd0);
        chk("rst_out_rd", {29'd0, out_rd}, 32'd0);
        chk("rst_out_we", {31'd0, out_we}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, one accept per cycle with out_ready high
        for (int i = 0; i < 12; i++) begin
            set_op(1'b1, vt[i].res, vt[i].c, vt[i].z, vt[i].v, vt[i].n, vt[i].mask,
                   vt[i].chain, vt[i].rd, vt[i].we);
            cond_sel = vt[i].sel;
            tick();
            chk("vec_flags", {28'd0, flags_q}, {28'd0, vt[i].ef});
            chk("vec_cond", {31'd0, cond_true}, {31'd0, vt[i].ec});
            chk("vec_result", {24'd0, out_result}, {24'd0, vt[i].res});
            chk("vec_rd", {29'd0, out_rd}, {29'd0, vt[i].rd});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill, ignored third op, ordered drain
        out_ready = 1'b0; cond_sel = 3'd3;
        set_op(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd5, 1'b1);
        tick();
        set_op(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd6, 1'b0);
        tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        set_op(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd1, 1'b1);
        tick();
        chk("full_flags_hold", {28'd0, flags_q}, 32'h1);
        chk("full_head", {24'd0, out_result}, 32'hAA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("pop_b_result", {24'd0, out_result}, 32'hBB);
        chk("pop_b_rd", {29'd0, out_rd}, 32'd6);
        chk("pop_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("pop_empty", {31'd0, out_valid}, 32'd0);

        // Mid-operation reset with two entries queued
        out_ready = 1'b0;
        set_op(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd2, 1'b1);
        tick();
        tick();
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("mid_rst_flags", {28'd0, flags_q}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_no_wb", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mid_no_wb2", {31'd0, out_valid}, 32'd0);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_op(1'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 4'($urandom), 1'($urandom), RD_W'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cond_sel  = 3'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
